window_addr_gen: RTL and testbench

Parametrised sliding-window address generator for the CFA pipeline. It replaces the fixed-5x5, stride-1, zero-pad-only addressing logic. It walks a frame of `rowMax` x `colMax` pixels and emits one K x K neighbourhood per output pixel as a stream of frame-buffer read addresses, one tap at a time. The window size, stride and border mode are configurable. The block sits between the frame-buffer read port and the window/line-buffer stage, and is throttled by that stage through `en`.

---
 rtl/window_addr_gen.sv | 253 +++++++++++++++++++++++++
 tb/tb_window_addr_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/window_addr_gen.sv
// rtl/window_addr_gen.sv - parametrised KxK sliding-window frame-buffer read address generator
// Walks a frame pixel by pixel and streams column-major window taps, full window per row start, new columns after.
module window_addr_gen #(
    parameter int ROW_W  = 11,
    parameter int COL_W  = 11,
    parameter int K      = 5,
    parameter int ADDR_W = ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  rowMax,
    input  logic [COL_W-1:0]  colMax,
    input  logic              stride,
    input  logic              padMode,
    input  logic              en,
    output logic [ADDR_W-1:0] address,
    output logic              addressValid,
    output logic              tapValid,
    output logic              ready,
    output logic              rowUpdateFlag,
    output logic              colUpdateFlag,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              busy,
    output logic              done
);
    localparam int P   = (K - 1) / 2;
    localparam int NP  = -P;
    localparam int ONE = 1;
    localparam int RW  = ROW_W + 2;
    localparam int CW  = COL_W + 2;

    localparam logic signed [RW-1:0] P_R       = P[RW-1:0];
    localparam logic signed [CW-1:0] P_C       = P[CW-1:0];
    localparam logic signed [RW-1:0] ONE_R     = ONE[RW-1:0];
    localparam logic signed [CW-1:0] ONE_C     = ONE[CW-1:0];
    localparam logic [ROW_W:0]       NEG_P_ROW = NP[ROW_W:0];
    localparam logic [COL_W:0]       NEG_P_COL = NP[COL_W:0];

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_PRIME  = 4'b0010,
        ST_STEADY = 4'b0100,
        ST_DONE   = 4'b1000
    } state_t;

    state_t state;
    state_t state_next;

    logic [ROW_W-1:0]      row_max_reg;
    logic [COL_W-1:0]      col_max_reg;
    logic                  stride_reg;
    logic                  pad_mode_reg;
    logic signed [ROW_W:0] tap_row;
    logic signed [COL_W:0] tap_col;

    // Two guard bits so window edges and next-pixel sums never wrap before comparison.
    logic signed [RW-1:0] row_w, tap_row_w, row_max_w, row_step;
    logic signed [RW-1:0] row_lo, row_hi, row_next_w, row_next_lo, row_inc, row_top_w;
    logic signed [CW-1:0] col_w, tap_col_w, col_max_w, col_step;
    logic signed [CW-1:0] col_lo, col_hi, col_new_lo, col_next_w, col_inc, col_top_w;

    assign row_w       = {2'b00, row};
    assign tap_row_w   = {tap_row[ROW_W], tap_row};
    assign row_max_w   = {2'b00, row_max_reg};
    assign row_step    = {{(RW-2){1'b0}}, stride_reg, ~stride_reg};
    assign row_lo      = row_w - P_R;
    assign row_hi      = row_w + P_R;
    assign row_next_w  = row_w + row_step;
    assign row_next_lo = row_next_w - P_R;
    assign row_inc     = tap_row_w + ONE_R;
    assign row_top_w   = row_max_w - ONE_R;

    assign col_w       = {2'b00, col};
    assign tap_col_w   = {tap_col[COL_W], tap_col};
    assign col_max_w   = {2'b00, col_max_reg};
    assign col_step    = {{(CW-2){1'b0}}, stride_reg, ~stride_reg};
    assign col_lo      = col_w - P_C;
    assign col_hi      = col_w + P_C;
    assign col_new_lo  = col_hi - col_step + ONE_C;
    assign col_next_w  = col_w + col_step;
    assign col_inc     = tap_col_w + ONE_C;
    assign col_top_w   = col_max_w - ONE_C;

    logic at_row_hi;
    logic last_tap;
    logic first_prime;
    logic first_steady;
    logic col_fits;
    logic row_fits;
    logic consume;
    logic in_frame;

    assign at_row_hi    = (tap_row_w == row_hi);
    assign last_tap     = at_row_hi && (tap_col_w == col_hi);
    assign first_prime  = (tap_row_w == row_lo) && (tap_col_w == col_lo);
    assign first_steady = (tap_row_w == row_lo) && (tap_col_w == col_new_lo);
    assign col_fits     = (col_next_w < col_max_w);
    assign row_fits     = (row_next_w < row_max_w);
    assign consume      = tapValid && en;
    assign in_frame     = !tap_row_w[RW-1] && (tap_row_w < row_max_w) &&
                          !tap_col_w[CW-1] && (tap_col_w < col_max_w);

    logic unused_ok;
    assign unused_ok = ^{row_lo, row_next_w, row_next_lo, row_inc, row_top_w,
                         col_next_w, col_inc, col_top_w};

    // Clamp checks the low side first so an unconfigured (zero) max still yields address 0.
    logic [ROW_W-1:0] tap_row_c;
    logic [COL_W-1:0] tap_col_c;

    always_comb begin
        tap_row_c = '0;
        if (!tap_row_w[RW-1] && (tap_row_w != '0)) begin
            if (tap_row_w >= row_max_w)
                tap_row_c = row_top_w[ROW_W-1:0];
            else
                tap_row_c = tap_row_w[ROW_W-1:0];
        end
    end

    always_comb begin
        tap_col_c = '0;
        if (!tap_col_w[CW-1] && (tap_col_w != '0)) begin
            if (tap_col_w >= col_max_w)
                tap_col_c = col_top_w[COL_W-1:0];
            else
                tap_col_c = tap_col_w[COL_W-1:0];
        end
    end

    assign address = ADDR_W'(tap_row_c) * ADDR_W'(col_max_reg) + ADDR_W'(tap_col_c);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_PRIME;
            end
            ST_PRIME, ST_STEADY: begin
                if (consume && last_tap) begin
                    if (col_fits)
                        state_next = ST_STEADY;
                    else if (row_fits)
                        state_next = ST_PRIME;
                    else
                        state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tapValid      = 1'b0;
        colUpdateFlag = 1'b0;
        rowUpdateFlag = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            ST_PRIME: begin
                tapValid      = 1'b1;
                busy          = 1'b1;
                colUpdateFlag = first_prime;
                rowUpdateFlag = first_prime && (row != '0);
            end
            ST_STEADY: begin
                tapValid      = 1'b1;
                busy          = 1'b1;
                colUpdateFlag = first_steady;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
        ready        = tapValid && last_tap;
        addressValid = tapValid && (pad_mode_reg || in_frame);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_max_reg  <= '0;
            col_max_reg  <= '0;
            stride_reg   <= 1'b0;
            pad_mode_reg <= 1'b0;
            row          <= '0;
            col          <= '0;
            tap_row      <= '0;
            tap_col      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        row_max_reg  <= rowMax;
                        col_max_reg  <= colMax;
                        stride_reg   <= stride;
                        pad_mode_reg <= padMode;
                        row          <= '0;
                        col          <= '0;
                        tap_row      <= NEG_P_ROW;
                        tap_col      <= NEG_P_COL;
                    end
                end
                ST_PRIME, ST_STEADY: begin
                    if (consume) begin
                        if (last_tap) begin
                            if (col_fits) begin
                                // Steady pixels only fetch the stride's worth of new right columns.
                                col     <= col_next_w[COL_W-1:0];
                                tap_row <= row_lo[ROW_W:0];
                                tap_col <= col_inc[COL_W:0];
                            end else if (row_fits) begin
                                row     <= row_next_w[ROW_W-1:0];
                                col     <= '0;
                                tap_row <= row_next_lo[ROW_W:0];
                                tap_col <= NEG_P_COL;
                            end else begin
                                row     <= '0;
                                col     <= '0;
                                tap_row <= '0;
                                tap_col <= '0;
                            end
                        end else if (at_row_hi) begin
                            tap_row <= row_lo[ROW_W:0];
                            tap_col <= col_inc[COL_W:0];
                        end else begin
                            tap_row <= row_inc[ROW_W:0];
                        end
                    end
                end
                default: begin
                    row     <= '0;
                    col     <= '0;
                    tap_row <= '0;
                    tap_col <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_addr_gen.sv
// tb/tb_window_addr_gen.sv - randomized bench for window_addr_gen against a per-pixel window model
module tb_window_addr_gen;
    localparam int ROW_W  = 11;
    localparam int COL_W  = 11;
    localparam int ADDR_W = ROW_W + COL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start3, start5, stride, pad_mode, en, sel;
    logic [ROW_W-1:0] row_max;
    logic [COL_W-1:0] col_max;

    logic [ADDR_W-1:0] address3, address5;
    logic [ROW_W-1:0]  row3, row5;
    logic [COL_W-1:0]  col3, col5;
    logic av3, tv3, rdy3, rf3, cf3, busy3, done3;
    logic av5, tv5, rdy5, rf5, cf5, busy5, done5;

    window_addr_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .K(3)) u_k3 (
        .clk(clk), .rst(rst), .start(start3), .rowMax(row_max), .colMax(col_max),
        .stride(stride), .padMode(pad_mode), .en(en), .address(address3),
        .addressValid(av3), .tapValid(tv3), .ready(rdy3), .rowUpdateFlag(rf3),
        .colUpdateFlag(cf3), .row(row3), .col(col3), .busy(busy3), .done(done3));

    window_addr_gen #(.ROW_W(ROW_W), .COL_W(COL_W), .K(5)) u_k5 (
        .clk(clk), .rst(rst), .start(start5), .rowMax(row_max), .colMax(col_max),
        .stride(stride), .padMode(pad_mode), .en(en), .address(address5),
        .addressValid(av5), .tapValid(tv5), .ready(rdy5), .rowUpdateFlag(rf5),
        .colUpdateFlag(cf5), .row(row5), .col(col5), .busy(busy5), .done(done5));

    logic [ADDR_W-1:0] o_address;
    logic [ROW_W-1:0]  o_row;
    logic [COL_W-1:0]  o_col;
    logic o_av, o_tv, o_rdy, o_rf, o_cf, o_busy, o_done;
    assign o_address = sel ? address5 : address3;
    assign o_row     = sel ? row5 : row3;
    assign o_col     = sel ? col5 : col3;
    assign o_av      = sel ? av5 : av3;
    assign o_tv      = sel ? tv5 : tv3;
    assign o_rdy     = sel ? rdy5 : rdy3;
    assign o_rf      = sel ? rf5 : rf3;
    assign o_cf      = sel ? cf5 : cf3;
    assign o_busy    = sel ? busy5 : busy3;
    assign o_done    = sel ? done5 : done3;

    typedef struct {
        int addr;
        bit aval;
        bit rdy;
        bit cf;
        bit rf;
        int r;
        int c;
    } tap_t;

    tap_t exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int mx);
        if (v < 0) return 0;
        if (v >= mx) return mx - 1;
        return v;
    endfunction

    // Each output pixel's window, with only the newly uncovered columns once a row is under way.
    function automatic void build(input int kk, input int rm, input int cm, input int s, input bit pd);
        int p, first_col;
        tap_t t;
        p = (kk - 1) / 2;
        exp_q.delete();
        for (int r = 0; r < rm; r += s) begin
            for (int c = 0; c < cm; c += s) begin
                first_col = (c == 0) ? c - p : c + p - s + 1;
                for (int tc = first_col; tc <= c + p; tc++) begin
                    for (int tr = r - p; tr <= r + p; tr++) begin
                        t.addr = clamp(tr, rm) * cm + clamp(tc, cm);
                        t.aval = pd || (tr >= 0 && tr < rm && tc >= 0 && tc < cm);
                        t.rdy  = (tc == c + p) && (tr == r + p);
                        t.cf   = (tc == first_col) && (tr == r - p);
                        t.rf   = t.cf && (c == 0) && (r > 0);
                        t.r    = r;
                        t.c    = c;
                        exp_q.push_back(t);
                    end
                end
            end
        end
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, "_addr"}, o_address, 0);
        check_val({tag, "_aval"}, o_av, 0);
        check_val({tag, "_tvalid"}, o_tv, 0);
        check_val({tag, "_ready"}, o_rdy, 0);
        check_val({tag, "_rflag"}, o_rf, 0);
        check_val({tag, "_cflag"}, o_cf, 0);
        check_val({tag, "_row"}, o_row, 0);
        check_val({tag, "_col"}, o_col, 0);
        check_val({tag, "_busy"}, o_busy, 0);
        check_val({tag, "_done"}, o_done, 0);
    endtask

    task automatic run_frame(input bit ks, input int rm, input int cm, input bit st, input bit pd,
                             input bit rnd_en, input int stall_at, input int rst_at,
                             input int bstart_at, input bit done_start, input int exp_taps);
        int idx, cyc, stall_cnt, total;
        bit all_en, finished, bs_fired;
        build(ks ? 5 : 3, rm, cm, st ? 2 : 1, pd);
        total = (exp_taps >= 0) ? exp_taps : exp_q.size();
        idx = 0; cyc = 0; stall_cnt = 0;
        all_en = 1'b1; finished = 1'b0; bs_fired = 1'b0;
        sel = ks;
        @(negedge clk);
        row_max = ROW_W'(rm); col_max = COL_W'(cm);
        stride = st; pad_mode = pd; en = 1'b1;
        if (ks) start5 = 1'b1; else start3 = 1'b1;
        while (!finished && cyc < 5000) begin
            @(negedge clk);
            start3 = 1'b0; start5 = 1'b0;
            cyc++;
            if (rst_at >= 0 && idx == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero("midrst");
                rst = 1'b0;
                return;
            end
            if (o_done) begin
                check_val("done_taps", idx, total);
                if (all_en) check_val("done_cycle", cyc, total + 1);
                check_val("done_tvalid", o_tv, 0);
                if (done_start) begin
                    if (ks) start5 = 1'b1; else start3 = 1'b1;
                end
                @(negedge clk);
                start3 = 1'b0; start5 = 1'b0;
                check_val("idle_busy", o_busy, 0);
                check_val("idle_tvalid", o_tv, 0);
                check_val("idle_addr", o_address, 0);
                finished = 1'b1;
            end else begin
                check_val("busy", o_busy, 1);
                check_val("tvalid", o_tv, 1);
                if (o_tv) begin
                    if (idx < exp_q.size()) begin
                        check_val("addr", o_address, exp_q[idx].addr);
                        check_val("aval", o_av, exp_q[idx].aval);
                        check_val("ready", o_rdy, exp_q[idx].rdy);
                        check_val("cflag", o_cf, exp_q[idx].cf);
                        check_val("rflag", o_rf, exp_q[idx].rf);
                        check_val("row", o_row, exp_q[idx].r);
                        check_val("col", o_col, exp_q[idx].c);
                    end else begin
                        check_val("extra_tap", idx, exp_q.size());
                    end
                    if (stall_at >= 0 && idx == stall_at && stall_cnt < 5) begin
                        en = 1'b0;
                        stall_cnt++;
                    end else if (rnd_en) begin
                        en = ($urandom_range(0, 3) != 0);
                    end else begin
                        en = 1'b1;
                    end
                    if (!en) all_en = 1'b0;
                    if (en) idx++;
                    if (bstart_at >= 0 && idx == bstart_at && !bs_fired) begin
                        bs_fired = 1'b1;
                        if (ks) start5 = 1'b1; else start3 = 1'b1;
                        row_max = ROW_W'(rm + 3);
                        col_max = COL_W'(cm + 2);
                        pad_mode = ~pd;
                    end
                end
            end
        end
        if (!finished) check_val("frame_timeout", cyc, total + 1);
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start3 = 1'b0; start5 = 1'b0; en = 1'b0;
        stride = 1'b0; pad_mode = 1'b0; row_max = '0; col_max = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        sel = 1'b0; #1;
        check_zero("rst_k3");
        sel = 1'b1; #1;
        check_zero("rst_k5");
        rst = 1'b0;

        run_frame(0, 4, 4, 0, 0, 0, -1, -1, -1, 0, 72);
        run_frame(0, 4, 4, 0, 1, 0, -1, -1, -1, 1, 72);
        run_frame(0, 5, 5, 1, 0, 0, -1, -1, -1, 0, 63);
        run_frame(0, 4, 4, 0, 0, 0, 9, -1, -1, 0, 72);
        run_frame(0, 5, 5, 0, 0, 0, -1, 29, -1, 0, -1);
        run_frame(0, 4, 4, 0, 0, 0, -1, -1, -1, 0, 72);
        run_frame(1, 1, 1, 0, 0, 0, -1, -1, -1, 0, 25);
        run_frame(1, 3, 4, 0, 1, 0, -1, -1, 20, 0, -1);
        for (int i = 0; i < 20; i++) begin
            run_frame(1'($urandom_range(0, 1)), $urandom_range(1, 8), $urandom_range(1, 8),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      -1, -1, -1, 1'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
